// File: rtl/console_txarbiter.sv
// rtl/console_txarbiter.sv - line-granular round-robin arbiter sharing one console TX stream
module console_txarbiter #(
  parameter int         LGTIMEOUT     = 10,
  parameter logic [6:0] NEWLINE       = 7'h0a,
  parameter bit         OPT_LINE_LOCK = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req0_stb,
  input  logic [6:0] i_req0_data,
  output logic       o_req0_busy,
  input  logic       i_req1_stb,
  input  logic [6:0] i_req1_data,
  output logic       o_req1_busy,
  output logic       o_console_stb,
  output logic [6:0] o_console_data,
  input  logic       i_console_busy,
  output logic [1:0] o_grant
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;
  // Releasing when the counter steps into all-ones: the edge after this value.
  localparam logic [LGTIMEOUT-1:0] TMO_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic                 r_last_gnt;
  logic                 w_next_last;
  logic                 w_release;
  logic [LGTIMEOUT-1:0] r_timeout;
  logic                 r_stb;
  logic [6:0]           r_data;
  logic                 w_stall;
  logic                 w_acc;
  logic [6:0]           w_acc_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_last_gnt <= w_next_last;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last_gnt;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req0_stb && (!i_req1_stb || r_last_gnt)) begin
          w_next_state = GNT0;
          w_next_last  = 1'b0;
        end else if (i_req1_stb) begin
          w_next_state = GNT1;
          w_next_last  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (w_acc)
          w_release = (w_acc_data == NEWLINE) || !OPT_LINE_LOCK;
        else
          w_release = (r_timeout == TMO_LAST);
        if (w_release)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Holding busy during reset keeps requesters from believing a byte was taken.
  always_comb begin
    w_stall     = r_stb && i_console_busy;
    o_req0_busy = i_reset || (r_state != GNT0) || w_stall;
    o_req1_busy = i_reset || (r_state != GNT1) || w_stall;
    w_acc       = 1'b0;
    w_acc_data  = i_req0_data;
    if (r_state == GNT0) begin
      w_acc      = i_req0_stb && !o_req0_busy;
      w_acc_data = i_req0_data;
    end else if (r_state == GNT1) begin
      w_acc      = i_req1_stb && !o_req1_busy;
      w_acc_data = i_req1_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timeout <= '0;
      r_stb     <= 1'b0;
      r_data    <= 7'h00;
    end else begin
      if ((r_state == IDLE) || w_acc)
        r_timeout <= '0;
      else
        r_timeout <= r_timeout + 1'b1;
      if (w_acc) begin
        r_stb  <= 1'b1;
        r_data <= w_acc_data;
      end else if (!i_console_busy) begin
        r_stb  <= 1'b0;
      end
    end
  end

  assign o_grant        = r_state;
  assign o_console_stb  = r_stb;
  assign o_console_data = r_data;

endmodule

// File: tb/tb_console_txarbiter.sv
// tb/tb_console_txarbiter.sv - directed bench for console_txarbiter (line lock and per-byte instances)
module tb_console_txarbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] rq_stb;
  logic [6:0] rq_data [4];
  wire  [3:0] rq_busy;
  logic       a_cbusy, b_cbusy;
  logic       a_cstb, b_cstb;
  logic [6:0] a_cdata, b_cdata;
  logic [1:0] a_grant, b_grant;

  int tests = 0;
  int fails = 0;

  logic [6:0] q0[$], q1[$], q2[$], q3[$];
  logic [6:0] out_a[$], out_b[$];
  int direct_a = 0, direct_b = 0;
  logic [3:0] xf;

  console_txarbiter #(.LGTIMEOUT(10), .NEWLINE(7'h0a), .OPT_LINE_LOCK(1'b1)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_stb(rq_stb[0]), .i_req0_data(rq_data[0]), .o_req0_busy(rq_busy[0]),
    .i_req1_stb(rq_stb[1]), .i_req1_data(rq_data[1]), .o_req1_busy(rq_busy[1]),
    .o_console_stb(a_cstb), .o_console_data(a_cdata), .i_console_busy(a_cbusy),
    .o_grant(a_grant)
  );

  console_txarbiter #(.LGTIMEOUT(10), .NEWLINE(7'h0a), .OPT_LINE_LOCK(1'b0)) dut_nl (
    .i_clk(clk), .i_reset(rst),
    .i_req0_stb(rq_stb[2]), .i_req0_data(rq_data[2]), .o_req0_busy(rq_busy[2]),
    .i_req1_stb(rq_stb[3]), .i_req1_data(rq_data[3]), .o_req1_busy(rq_busy[3]),
    .o_console_stb(b_cstb), .o_console_data(b_cdata), .i_console_busy(b_cbusy),
    .o_grant(b_grant)
  );

  // Requester models: hold stb/data until a transfer is seen, then advance.
  initial begin
    rq_stb = '0;
    for (int k = 0; k < 4; k++) rq_data[k] = 7'h00;
    forever begin
      @(negedge clk);
      xf = rq_stb & ~rq_busy;
      @(posedge clk); #1;
      if (xf[0]) void'(q0.pop_front());
      if (xf[1]) void'(q1.pop_front());
      if (xf[2]) void'(q2.pop_front());
      if (xf[3]) void'(q3.pop_front());
      rq_stb[0] = (q0.size() > 0); rq_data[0] = (q0.size() > 0) ? q0[0] : 7'h00;
      rq_stb[1] = (q1.size() > 0); rq_data[1] = (q1.size() > 0) ? q1[0] : 7'h00;
      rq_stb[2] = (q2.size() > 0); rq_data[2] = (q2.size() > 0) ? q2[0] : 7'h00;
      rq_stb[3] = (q3.size() > 0); rq_data[3] = (q3.size() > 0) ? q3[0] : 7'h00;
    end
  end

  logic [1:0] prev_ga = 2'b00, prev_gb = 2'b00;
  initial begin
    forever begin
      @(negedge clk);
      if (a_cstb === 1'b1 && a_cbusy == 1'b0) out_a.push_back(a_cdata);
      if (b_cstb === 1'b1 && b_cbusy == 1'b0) out_b.push_back(b_cdata);
      if (prev_ga != 2'b00 && a_grant != 2'b00 && prev_ga != a_grant) direct_a++;
      if (prev_gb != 2'b00 && b_grant != 2'b00 && prev_gb != b_grant) direct_b++;
      prev_ga = a_grant;
      prev_gb = b_grant;
    end
  end

  task automatic push_str(input int ch, input string t);
    byte b;
    for (int i = 0; i < t.len(); i++) begin
      b = t[i];
      case (ch)
        0: q0.push_back(b[6:0]);
        1: q1.push_back(b[6:0]);
        2: q2.push_back(b[6:0]);
        default: q3.push_back(b[6:0]);
      endcase
    end
  endtask

  function automatic string fmt_out(input bit sel);
    string s = "";
    if (!sel) foreach (out_a[i]) s = {s, $sformatf("%02h ", out_a[i])};
    else      foreach (out_b[i]) s = {s, $sformatf("%02h ", out_b[i])};
    return s;
  endfunction

  function automatic string fmt_str(input string t);
    string s = "";
    for (int i = 0; i < t.len(); i++) s = {s, $sformatf("%02h ", t[i])};
    return s;
  endfunction

  task automatic wait_idle(input bit sel, input int lim, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (!sel && q0.size() == 0 && q1.size() == 0 && a_grant == 2'b00 && a_cstb == 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (sel && q2.size() == 0 && q3.size() == 0 && b_grant == 2'b00 && b_cstb == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    tests++; if (a_grant !== 2'b00) begin fails++; $display("FAIL reset_grant got %b want 00", a_grant); end
    tests++; if (a_cstb !== 1'b0) begin fails++; $display("FAIL reset_stb got %b want 0", a_cstb); end
    tests++; if (a_cdata !== 7'h00) begin fails++; $display("FAIL reset_data got %h want 00", a_cdata); end
    tests++; if (rq_busy[1:0] !== 2'b11) begin fails++; $display("FAIL reset_busy got %b want 11", rq_busy[1:0]); end
    tests++; if (b_grant !== 2'b00) begin fails++; $display("FAIL reset_grant_nl got %b want 00", b_grant); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_line();
    bit ok;
    @(negedge clk); push_str(0, "AB\n");
    @(negedge clk);
    tests++; if (a_grant !== 2'b00 || rq_busy[0] !== 1'b1) begin fails++; $display("FAIL line_pre grant %b busy0 %b want 00/1", a_grant, rq_busy[0]); end
    @(negedge clk);
    tests++; if (a_grant !== 2'b01 || a_cstb !== 1'b0) begin fails++; $display("FAIL line_grant grant %b stb %b want 01/0", a_grant, a_cstb); end
    @(negedge clk);
    tests++; if (a_cstb !== 1'b1 || a_cdata !== 7'h41) begin fails++; $display("FAIL line_b0 stb %b data %h want 1/41", a_cstb, a_cdata); end
    @(negedge clk);
    tests++; if (a_cstb !== 1'b1 || a_cdata !== 7'h42) begin fails++; $display("FAIL line_b1 stb %b data %h want 1/42", a_cstb, a_cdata); end
    @(negedge clk);
    tests++; if (a_cdata !== 7'h0a || a_grant !== 2'b00) begin fails++; $display("FAIL line_nl data %h grant %b want 0a/00", a_cdata, a_grant); end
    @(negedge clk);
    tests++; if (a_cstb !== 1'b0) begin fails++; $display("FAIL line_drain stb %b want 0", a_cstb); end
    wait_idle(1'b0, 20, ok);
    tests++; if (fmt_out(1'b0) != fmt_str("AB\n")) begin fails++; $display("FAIL line_stream got %s want %s", fmt_out(1'b0), fmt_str("AB\n")); end
    out_a.delete();
  endtask

  task automatic test_tie();
    bit ok;
    do_reset();
    @(negedge clk); push_str(0, "C\n"); push_str(1, "x\n");
    @(negedge clk);
    @(negedge clk);
    tests++; if (a_grant !== 2'b01) begin fails++; $display("FAIL tie_first grant %b want 01", a_grant); end
    wait_idle(1'b0, 40, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL tie_done1 timeout got %b want 1", ok); end
    @(negedge clk); push_str(0, "D\n"); push_str(1, "y\n");
    wait_idle(1'b0, 40, ok);
    tests++; if (fmt_out(1'b0) != fmt_str("C\nx\nD\ny\n")) begin fails++; $display("FAIL tie_stream got %s want %s", fmt_out(1'b0), fmt_str("C\nx\nD\ny\n")); end
    out_a.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int rel = 0, g0 = 0, busy_bad = 0;
    @(negedge clk); push_str(1, "xy");
    for (int n = 0; n < 10 && a_grant != 2'b10; n++) @(negedge clk);
    push_str(0, "E\n");
    for (int n = 0; n < 10 && q1.size() != 0; n++) @(negedge clk);
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      if (a_grant != 2'b01 && rq_busy[0] !== 1'b1) busy_bad++;
      if (n == 1022) begin
        tests++; if (a_grant !== 2'b10) begin fails++; $display("FAIL tmo_hold grant %b want 10", a_grant); end
      end
      if (a_grant == 2'b00 && rel == 0) rel = n;
      if (a_grant == 2'b01) begin g0 = n; break; end
    end
    tests++; if (rel != 1023) begin fails++; $display("FAIL tmo_release cycle %0d want 1023", rel); end
    tests++; if (g0 != 1024) begin fails++; $display("FAIL tmo_regrant cycle %0d want 1024", g0); end
    tests++; if (busy_bad != 0) begin fails++; $display("FAIL tmo_busy0 low %0d cycles want 0", busy_bad); end
    wait_idle(1'b0, 40, ok);
    tests++; if (fmt_out(1'b0) != fmt_str("xyE\n")) begin fails++; $display("FAIL tmo_stream got %s want %s", fmt_out(1'b0), fmt_str("xyE\n")); end
    out_a.delete();
  endtask

  task automatic test_console_stall();
    bit ok;
    @(negedge clk); push_str(0, "FG\n");
    for (int n = 0; n < 10 && a_cstb != 1'b1; n++) @(negedge clk);
    @(posedge clk); #1 a_cbusy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (a_cstb !== 1'b1 || a_cdata !== 7'h47 || rq_busy[0] !== 1'b1) begin
        fails++; $display("FAIL stall_c%0d stb %b data %h busy0 %b want 1/47/1", c, a_cstb, a_cdata, rq_busy[0]);
      end
    end
    @(posedge clk); #1 a_cbusy = 1'b0;
    wait_idle(1'b0, 20, ok);
    tests++; if (fmt_out(1'b0) != fmt_str("FG\n")) begin fails++; $display("FAIL stall_stream got %s want %s", fmt_out(1'b0), fmt_str("FG\n")); end
    out_a.delete();
  endtask

  task automatic test_no_lock();
    bit ok;
    @(negedge clk); push_str(2, "abc"); push_str(3, "123");
    wait_idle(1'b1, 60, ok);
    tests++; if (fmt_out(1'b1) != fmt_str("a1b2c3")) begin fails++; $display("FAIL nolock_stream got %s want %s", fmt_out(1'b1), fmt_str("a1b2c3")); end
    tests++; if (direct_b != 0) begin fails++; $display("FAIL nolock_direct got %0d want 0", direct_b); end
  endtask

  task automatic test_reset_midline();
    @(posedge clk); #1 a_cbusy = 1'b1;
    @(negedge clk); push_str(1, "zw");
    for (int n = 0; n < 10 && a_cstb != 1'b1; n++) @(negedge clk);
    tests++; if (a_grant !== 2'b10 || a_cdata !== 7'h7a) begin fails++; $display("FAIL mid_owner grant %b data %h want 10/7a", a_grant, a_cdata); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    tests++; if (rq_busy[1:0] !== 2'b11) begin fails++; $display("FAIL mid_busy got %b want 11", rq_busy[1:0]); end
    q0.delete(); q1.delete();
    @(posedge clk); #1 rst = 1'b0; a_cbusy = 1'b0;
    @(negedge clk);
    tests++; if (a_cstb !== 1'b0 || a_grant !== 2'b00) begin fails++; $display("FAIL mid_clear stb %b grant %b want 0/00", a_cstb, a_grant); end
    tests++; if (rq_busy[1:0] !== 2'b11) begin fails++; $display("FAIL mid_idle_busy got %b want 11", rq_busy[1:0]); end
    @(negedge clk);
    tests++; if (a_grant !== 2'b00) begin fails++; $display("FAIL mid_stay grant %b want 00", a_grant); end
    tests++; if (out_a.size() != 0) begin fails++; $display("FAIL mid_lost got %s want none", fmt_out(1'b0)); end
  endtask

  initial begin
    rst = 1'b1;
    a_cbusy = 1'b0;
    b_cbusy = 1'b0;
    test_reset();
    test_line();
    test_tie();
    test_timeout();
    test_console_stall();
    test_no_lock();
    test_reset_midline();
    tests++; if (direct_a != 0) begin fails++; $display("FAIL direct_handoff got %0d want 0", direct_a); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
